key_repeat_events: RTL
======================

Name: key_repeat_events

Overview:
Turns the settled, debounced button levels from the front-panel debouncer into discrete key events for the Z8 core's I/O port logic. For each of two channels it emits a one-cycle press pulse, a one-cycle release pulse, and an "event" pulse on press and on every auto-repeat while the key is held. It sits between the debouncer outputs and the port/interrupt logic. It is fully synchronous to the system clock.

Parameters:
COUNT_BITS, 16, width of each per-channel repeat counter.
DELAY_CYCLES, 1000, clk cycles from the press event to the first repeat event. Legal range 1..2^COUNT_BITS.
RATE_CYCLES, 250, clk cycles between consecutive repeat events. Legal range 1..2^COUNT_BITS.

Ports:
clk  input  1  system clock, all logic on posedge.
reset_n  input  1  reset, synchronous, active-low.
repeatEn  input  1  global auto-repeat enable.
in1  input  1  debounced level, channel 1 (already synchronous to clk).
in2  input  1  debounced level, channel 2.
press1 / press2  output  1  one-cycle pulse on the rising level.
release1 / release2  output  1  one-cycle pulse on the falling level.
event1 / event2  output  1  one-cycle pulse on press and on each auto-repeat.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a posedge):
  - all outputs go to 0; prev levels go to 0; counters go to 0; all channels enter IDLE.
  - Reset asserted mid-hold aborts the hold silently: no release pulse.
- Channels are fully independent. Simultaneous edges on both channels give simultaneous pulses.
- All outputs are registered. A level change sampled at edge k produces its pulse high during the cycle after edge k. Latency is 1 clk.
- Per-channel FSM: IDLE, DELAY, REPEAT, HELD.
- IDLE:
  - in=1 and prev=0 at edge k → press=1 and event=1 after edge k; count←0.
  - Next state is DELAY if repeatEn=1, otherwise HELD.
- DELAY:
  - If count==DELAY_CYCLES-1: event=1, count←0, next state REPEAT.
  - Otherwise count←count+1.
  - First repeat therefore appears after edge k+DELAY_CYCLES.
- REPEAT:
  - If count==RATE_CYCLES-1: event=1, count←0.
  - Otherwise count←count+1.
  - Repeats appear after edges k+DELAY+n·RATE.
- HELD: no events.
  - repeatEn rising while the key is held → DELAY with count←0, so the delay restarts in full.
- repeatEn=0 sampled in DELAY or REPEAT → HELD, count←0, no event that cycle.
- Falling level (in=0, prev=1) from any non-IDLE state:
  - release=1 after that edge; next state IDLE; count←0.
  - Release wins over a repeat due in the same cycle: event stays 0.
- press and release are never both 1 on the same channel.
- After reset, a key already held produces a press one cycle after reset deasserts, because prev resets to 0.
- Counter never wraps. The comparison against X-1 always fires before overflow, given the legal parameter ranges.
- prev←in every non-reset cycle.
- Pulses last exactly one cycle; outputs return to 0 on the following edge unless a new event occurs.

Decomposition:
- Shared include/package holds:
  - 2-bit FSM state constants: ST_IDLE=0, ST_DELAY=1, ST_REPEAT=2, ST_HELD=3.
  - Parameter legality checks, as an initial-block $error in simulation.
- Sub-module key_repeat_channel:
  - Contains one channel's FSM, counter, prev register and three output registers, with the same parameters.
  - Instantiated twice by the top, which only fans out repeatEn, clk and reset_n.

Test Plan:
1. DELAY=8, RATE=4, repeatEn=1; in1 rises at edge 10 and is held. Required: press1 and event1 after edge 10; event1 after edges 18, 22, 26; no other pulses.
2. Continue test 1; in1 falls at edge 30, which coincides with a due repeat. Required: release1 after edge 30; event1 stays 0 at 30; channel back in IDLE.
3. in1 and in2 rise together at edge 5, in2 falls at edge 7. Required: press1 and press2 after edge 5; release2 after edge 7; event1 repeats after edge 13 unaffected.
4. repeatEn=0; in1 held from edge 3 for 40 cycles. Required: single press1/event1 after edge 3, then no events. Raise repeatEn at edge 20: next event1 after edge 28.
5. reset_n=0 at edge 15 while in1 has been held since edge 2. Required: all outputs 0 after edge 15 and no release1. reset_n=1 from edge 16 with in1 still high: press1 after edge 16.
6. DELAY=1, RATE=1; in2 held from edge 4. Required: event2 high after edges 4, 5, 6, … every cycle; press2 only after edge 4.

Source files
------------

// File: rtl/key_repeat_events_pkg.sv
// Shared definitions for the key repeat event generator: channel FSM states
// and the parameter legality check used at elaboration.
package key_repeat_events_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } key_state_e;

  // Both intervals must be 1..2^bits so that "count == X-1" fires before the counter would wrap.
  function automatic bit params_legal(input int bits, input longint delay_cycles,
                                      input longint rate_cycles);
    longint limit;
    limit = longint'(1) << bits;
    return (bits >= 1) && (delay_cycles >= 1) && (rate_cycles >= 1) &&
           (delay_cycles <= limit) && (rate_cycles <= limit);
  endfunction

endpackage

// File: rtl/key_repeat_events_channel.sv
// One key channel: edge detection, press/delay/repeat/held FSM and registered
// one-cycle press, release and event pulses.
module key_repeat_channel
  import key_repeat_events_pkg::*;
#(
  parameter int COUNT_BITS   = 16,
  parameter int DELAY_CYCLES = 1000,
  parameter int RATE_CYCLES  = 250
) (
  input  logic clk,
  input  logic reset_n,
  input  logic repeat_en,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic event_pulse
);

  if (!params_legal(COUNT_BITS, longint'(DELAY_CYCLES), longint'(RATE_CYCLES))) begin : g_param_error
    $error("key_repeat_channel: DELAY_CYCLES and RATE_CYCLES must lie in 1..2^COUNT_BITS");
  end

  localparam logic [COUNT_BITS-1:0] DELAY_LAST = COUNT_BITS'(DELAY_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] RATE_LAST  = COUNT_BITS'(RATE_CYCLES - 1);

  key_state_e            state_reg, state_next;
  logic [COUNT_BITS-1:0] count_reg, count_next;
  logic                  prev_reg;
  logic                  press_reg, press_next;
  logic                  release_reg, release_next;
  logic                  event_reg, event_next;

  logic rise, fall;
  assign rise = level & ~prev_reg;
  assign fall = ~level & prev_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      prev_reg    <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      event_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      prev_reg    <= level;
      press_reg   <= press_next;
      release_reg <= release_next;
      event_reg   <= event_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    event_next   = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (rise) begin
        press_next = 1'b1;
        event_next = 1'b1;
        count_next = '0;
        state_next = repeat_en ? ST_DELAY : ST_HELD;
      end
    end else if (fall) begin
      // Release takes priority over any repeat due on the same edge.
      release_next = 1'b1;
      count_next   = '0;
      state_next   = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_DELAY, ST_REPEAT: begin
          if (!repeat_en) begin
            count_next = '0;
            state_next = ST_HELD;
          end else if (count_reg == ((state_reg == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
            event_next = 1'b1;
            count_next = '0;
            state_next = ST_REPEAT;
          end else begin
            count_next = count_reg + COUNT_BITS'(1);
          end
        end
        ST_HELD: begin
          // HELD is only entered with repeat disabled, so seeing it high means it was re-enabled.
          if (repeat_en) begin
            count_next = '0;
            state_next = ST_DELAY;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign event_pulse   = event_reg;

endmodule

// File: rtl/key_repeat_events.sv
// Two-channel key event generator: fans the shared clock, reset and repeat
// enable out to two independent key_repeat_channel instances.
module key_repeat_events
  import key_repeat_events_pkg::*;
#(
  parameter int COUNT_BITS   = 16,
  parameter int DELAY_CYCLES = 1000,
  parameter int RATE_CYCLES  = 250
) (
  input  logic clk,
  input  logic reset_n,
  input  logic repeatEn,
  input  logic in1,
  input  logic in2,
  output logic press1,
  output logic press2,
  output logic release1,
  output logic release2,
  output logic event1,
  output logic event2
);

  logic [1:0] level_vec;
  logic [1:0] press_vec;
  logic [1:0] release_vec;
  logic [1:0] event_vec;

  assign level_vec = {in2, in1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    key_repeat_channel #(
      .COUNT_BITS  (COUNT_BITS),
      .DELAY_CYCLES(DELAY_CYCLES),
      .RATE_CYCLES (RATE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .repeat_en    (repeatEn),
      .level        (level_vec[gi]),
      .press_pulse  (press_vec[gi]),
      .release_pulse(release_vec[gi]),
      .event_pulse  (event_vec[gi])
    );
  end

  assign press1   = press_vec[0];
  assign press2   = press_vec[1];
  assign release1 = release_vec[0];
  assign release2 = release_vec[1];
  assign event1   = event_vec[0];
  assign event2   = event_vec[1];

endmodule
